// File: rtl/multiply_2.sv
// Word-serial multiply-by-2: out = (in << 1) mod 2^N, one W-bit word per clock,
// least-significant word first, with the bit shifted out of in[N-1] on carry_out.
module multiply_2 #(
    parameter int N = 128,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in,
    output logic [N-1:0] out,
    output logic         done,
    output logic         carry_out,
    output logic [1:0]   state
);

    localparam int NW = N / W;
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [IW-1:0] LAST = IW'(NW - 1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         cur_state;
    logic [N-1:0]   op_buf;
    logic [IW-1:0]  idx;
    logic           c;
    logic [W-1:0]   cur_word;

    // done is a sticky completion flag, not a handshake: no consumer acknowledge
    // exists, so the result simply holds until the next rst.
    assign state = cur_state;

    always_comb begin
        cur_word = '0;
        for (int k = 0; k < NW; k++) begin
            if (idx == IW'(k)) begin
                cur_word = op_buf[k*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= LOAD;
            out       <= '0;
            done      <= 1'b0;
            carry_out <= 1'b0;
            op_buf    <= '0;
            idx       <= '0;
            c         <= 1'b0;
        end else begin
            case (cur_state)
                LOAD: begin
                    op_buf    <= in;
                    idx       <= '0;
                    c         <= 1'b0;
                    cur_state <= SHIFT;
                end
                SHIFT: begin
                    for (int k = 0; k < NW; k++) begin
                        if (idx == IW'(k)) begin
                            out[k*W +: W] <= {cur_word[W-2:0], c};
                        end
                    end
                    c <= cur_word[W-1];
                    if (idx == LAST) begin
                        done      <= 1'b1;
                        carry_out <= cur_word[W-1];
                        cur_state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    cur_state <= DONE;
                end
                default: begin
                    cur_state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiply_2.sv
// Self-checking bench for multiply_2: a 128/32 instance for the main scenarios
// and a single-word 32/32 instance for the one-word boundary.
module tb_multiply_2;

    logic         clk;
    logic         rst;
    logic [127:0] in_a;
    logic [127:0] out_a;
    logic         done_a;
    logic         carry_a;
    logic [1:0]   state_a;
    logic [31:0]  in_b;
    logic [31:0]  out_b;
    logic         done_b;
    logic         carry_b;
    logic [1:0]   state_b;

    logic [128:0] exp_q[$];
    logic [32:0]  exp_q_b[$];

    int checks;
    int errors;

    multiply_2 #(.N(128), .W(32)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in_a),
        .out       (out_a),
        .done      (done_a),
        .carry_out (carry_a),
        .state     (state_a)
    );

    multiply_2 #(.N(32), .W(32)) u_small (
        .clk       (clk),
        .rst       (rst),
        .in        (in_b),
        .out       (out_b),
        .done      (done_b),
        .carry_out (carry_b),
        .state     (state_b)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [128:0] got, input logic [128:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // driver: hold reset for one edge with the new operand, then release
    task automatic start_op(input logic [127:0] val);
        @(negedge clk);
        rst  = 1'b1;
        in_a = val;
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back({val[127], val << 1});
    endtask

    // counts edges after release until done; a blown budget shows up as a latency failure
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done_a && cycles < 50) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    // scoreboard: pop the expected result when the DUT reports completion
    task automatic score(input string tag, input int cycles);
        logic [128:0] exp;
        check_eq({tag, " latency"}, 129'(cycles), 129'd5);
        if (exp_q.size() == 0) begin
            check_eq({tag, " queue"}, 129'd0, 129'd1);
        end else begin
            exp = exp_q.pop_front();
            check_eq({tag, " out"}, {1'b0, out_a}, {1'b0, exp[127:0]});
            check_eq({tag, " carry"}, {128'd0, carry_a}, {128'd0, exp[128]});
        end
    endtask

    task automatic run_op(input string tag, input logic [127:0] val);
        int cycles;
        start_op(val);
        wait_done(cycles);
        score(tag, cycles);
    endtask

    initial begin
        int cycles;
        logic [127:0] hold_val;
        logic [127:0] rnd;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        in_a   = '0;
        in_b   = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset out", {1'b0, out_a}, 129'd0);
        check_eq("reset done", {128'd0, done_a}, 129'd0);
        check_eq("reset carry", {128'd0, carry_a}, 129'd0);
        check_eq("reset state", {127'd0, state_a}, 129'd0);

        // 1: cross-word carries with a set top word
        run_op("t1", {32'h0000_0001, 32'h4000_0000, 64'h0});
        // 2: bit 31 crosses into word 1
        run_op("t2", 128'h0000_0000_0000_0000_0000_0000_8000_0000);
        // 3: all ones
        run_op("t3", {128{1'b1}});
        // zero operand
        run_op("t_zero", 128'h0);

        // 4: in changes after LOAD must be ignored; unwritten words stay zero
        hold_val = 128'h8000_0001_8000_0001_8000_0001_8000_0001;
        start_op(hold_val);
        @(posedge clk);
        #1;
        in_a = 128'h1;
        @(posedge clk);
        #1;
        check_eq("t4 partial upper", {33'd0, out_a[127:32]}, 129'd0);
        check_eq("t4 partial done", {128'd0, done_a}, 129'd0);
        cycles = 2;
        while (!done_a && cycles < 50) begin
            @(posedge clk);
            #1;
            in_a = 128'h1;
            cycles++;
        end
        score("t4", cycles);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            in_a = 128'(i);
            check_eq("t4 hold done", {128'd0, done_a}, 129'd1);
            check_eq("t4 hold out", {1'b0, out_a}, {1'b0, hold_val << 1});
        end

        // 5: reset pulse in the middle of SHIFT
        start_op(128'h1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        void'(exp_q.pop_back());
        @(posedge clk);
        #1;
        check_eq("t5 abort done", {128'd0, done_a}, 129'd0);
        check_eq("t5 abort out", {1'b0, out_a}, 129'd0);
        check_eq("t5 abort state", {127'd0, state_a}, 129'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back({1'b0, 128'h2});
        wait_done(cycles);
        score("t5", cycles);

        // random operands
        for (int i = 0; i < 6; i++) begin
            rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (i == 0) rnd[127] = 1'b1;
            if (i == 1) rnd[127] = 1'b0;
            rnd[31 + 32*($urandom_range(0, 2))] = 1'b1;
            run_op("rand", rnd);
        end

        // 6: single-word instance
        @(negedge clk);
        rst  = 1'b1;
        in_b = 32'hC000_0001;
        exp_q_b.push_back({1'b1, 32'h8000_0002});
        @(negedge clk);
        rst = 1'b0;
        cycles = 0;
        while (!done_b && cycles < 50) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check_eq("t6 latency", 129'(cycles), 129'd2);
        begin
            logic [32:0] eb;
            eb = exp_q_b.pop_front();
            check_eq("t6 out", {97'd0, out_b}, {97'd0, eb[31:0]});
            check_eq("t6 carry", {128'd0, carry_b}, {128'd0, eb[32]});
        end

        check_eq("queue drained", 129'(exp_q.size()), 129'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multiply_2.md
Name: multiply_2

Overview:
- Word-serial multiply-by-2 of a packed N-bit value. Computes out = (in << 1) mod 2^N and reports the bit shifted out.
- Forward counterpart of divide_2 in the Toom-K datapath. Used in the evaluation stage; divide_2 performs the matching halving during interpolation.
- Processes one W-bit word per cycle, least-significant word first. The carry propagates across word boundaries.
- Same self-starting interface as divide_2: the operation runs once after reset is released.

Parameters:
- N, 128, total operand width in bits. Must be a nonzero multiple of W.
- W, 32, word width processed per cycle. Must be at least 2.
- NW, N/W, number of words. Derived localparam, not overridable.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  N  operand; word k occupies bits [k*W+W-1 : k*W].
- out  output  N  result register; valid when done=1.
- done  output  1  high once the result is complete; stays high until rst.
- carry_out  output  1  original in[N-1]; valid when done=1.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high, sampled only on the rising clk edge.
  - While rst=1 at an edge: state=LOAD, out=0, done=0, carry_out=0, internal buffer=0, word index idx=0, internal carry c=0.
- State machine: LOAD -> SHIFT -> DONE.
- LOAD: first edge with rst=0.
  - buf <= in, idx <= 0, c <= 0, go to SHIFT.
  - in is sampled only here. Changes to in afterwards are ignored.
- SHIFT: one word per edge.
  - out word idx <= {buf word idx[W-2:0], c}.
  - c <= buf word idx[W-1].
  - If idx == NW-1: done <= 1, carry_out <= buf word idx[W-1], go to DONE. Otherwise idx <= idx+1.
- DONE: all registers hold. done stays 1 indefinitely, with no restart until rst.
- Latency:
  - done is visible after edge NW+1, counting the first edge with rst=0 as edge 1.
  - For N=128, W=32: 5 cycles.
- Partial results: words of out not yet written stay 0. out is only guaranteed correct when done=1, and the bench checks out only then.
- Arithmetic:
  - Pure logical shift. No sign handling; the result wraps modulo 2^N.
  - The bit shifted out of bit N-1 appears only on carry_out.
- Boundaries:
  - NW=1: LOAD then a single SHIFT cycle. done after edge 2; out={in[W-2:0],0}.
  - The carry from word k lands in bit 0 of word k+1, never in word 0.
  - in=0 gives out=0 and carry_out=0.
- Reset mid-operation: rst=1 on any edge, in any state, returns to the reset values above at that edge. The next rst=0 edge performs a fresh LOAD of the current in.
- Idx counter is sized clog2(NW) with a minimum of 1 bit. It never exceeds NW-1.

Test Plan:
1. N=128, W=32, in={32'h00000001,32'h40000000,64'h0}, release rst -> done rises after 5 edges; out={32'h00000002,32'h80000000,64'h0}; carry_out=0.
2. in=128'h0000_0000_0000_0000_0000_0000_8000_0000 (bit 31 set) -> out has only bit 32 set (cross-word carry); carry_out=0.
3. in=all ones -> out={ {127{1'b1}},1'b0 } (128'hFFFF...FFFE); carry_out=1.
4. After LOAD, change in to 128'h1 every cycle -> result reflects the originally loaded value only. Also check: before done, unwritten out words are 0; after done, done stays 1 and out is stable for 20 cycles.
5. Assert rst for 1 cycle during SHIFT (after edge 3) with in=128'h1 -> done=0 and out=0 immediately; after release, done after 5 edges with out=128'h2 and carry_out=0.
6. Instantiate N=32, W=32 with in=32'hC0000001 -> done after 2 edges; out=32'h80000002; carry_out=1.
